store_monitor: RTL and testbench

Synthesizable self-checking store monitor for processor-level tests. It watches the data-memory write bus of the single-cycle core (`memwrite`, `dataadr`, `writedata`) and compares each store against a programmable, ordered table of up to DEPTH expected (address, data) pairs. It reports pass, mismatch or timeout with capture of the offending store. It sits beside `top` in test harnesses and FPGA bring-up builds, replacing ad-hoc per-program checks in benches.

---
 rtl/store_monitor.sv | 164 ++++++++++++++++
 tb/tb_store_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// store_monitor
//   Watches the core's data-memory write bus and checks each store, in
//   order, against a programmable table of expected (address, data) pairs.
//   Ends a run in PASS (all expected stores seen), FAIL/mismatch (a store
//   differs from the next expected entry, offending store captured) or
//   FAIL/timeout (TIMEOUT consecutive cycles without a store).
//
// Optional feature macro: STORE_MONITOR_IGNORE_EN
//   When defined, stores to IGNORE_ADR are skipped (loop scratch address)
//   and only restart the timeout counter.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   ld_en/ld_idx/ld_adr/ld_data   table write port (ignored while busy)
//   num_exp, start        number of entries to check; start pulse
//   memwrite/dataadr/writedata    core store bus
//   busy, done, pass      run status
//   fail_cause            0 none, 1 mismatch, 2 timeout
//   fail_adr, fail_data   mismatching store
//   match_cnt             stores matched so far in this run
module store_monitor #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 1024,
    parameter int IGNORE_ADR = 80,
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW        = $clog2(DEPTH + 1),
    localparam int TW        = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_en,
    input  logic [IW-1:0] ld_idx,
    input  logic [AW-1:0] ld_adr,
    input  logic [DW-1:0] ld_data,
    input  logic [NW-1:0] num_exp,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [1:0]    fail_cause,
    output logic [AW-1:0] fail_adr,
    output logic [DW-1:0] fail_data,
    output logic [NW-1:0] match_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t        r_state, w_state_nxt;
    logic [NW-1:0] r_cnt, w_cnt_nxt;
    logic [NW-1:0] r_match_cnt, w_match_nxt;
    logic [1:0]    r_cause, w_cause_nxt;
    logic [AW-1:0] r_fail_adr, w_fail_adr_nxt;
    logic [DW-1:0] r_fail_data, w_fail_data_nxt;
    logic [TW-1:0] r_to, w_to_nxt;

    // Expected-store table: deliberately not reset so a harness can reload
    // once and re-run after reset.
    logic [AW-1:0] r_tab_adr  [DEPTH];
    logic [DW-1:0] r_tab_data [DEPTH];

    logic [IW-1:0] w_idx;
    logic [NW-1:0] w_match_inc;
    logic [NW-1:0] w_num_clamp;
    logic          w_hit;
    logic          w_skip;

    always_ff @(posedge clk) begin
        if (ld_en && r_state != S_RUN && 32'(ld_idx) < DEPTH) begin
            r_tab_adr[ld_idx]  <= ld_adr;
            r_tab_data[ld_idx] <= ld_data;
        end
    end

    // match_cnt < count <= DEPTH while running, so its low bits index the table.
    assign w_idx       = r_match_cnt[IW-1:0];
    assign w_match_inc = r_match_cnt + NW'(1);
    assign w_num_clamp = (32'(num_exp) > DEPTH) ? NW'(DEPTH) : num_exp;
    assign w_hit       = (dataadr == r_tab_adr[w_idx]) && (writedata == r_tab_data[w_idx]);

`ifdef STORE_MONITOR_IGNORE_EN
    assign w_skip = (dataadr == AW'(IGNORE_ADR));
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_match_nxt     = r_match_cnt;
        w_cause_nxt     = r_cause;
        w_fail_adr_nxt  = r_fail_adr;
        w_fail_data_nxt = r_fail_data;
        w_to_nxt        = r_to;
        case (r_state)
            S_RUN: begin
                // A store always takes priority over an expiring timeout.
                if (memwrite) begin
                    if (w_skip) begin
                        w_to_nxt = '0;
                    end else if (w_hit) begin
                        w_match_nxt = w_match_inc;
                        w_to_nxt    = '0;
                        if (w_match_inc == r_cnt) w_state_nxt = S_PASS;
                    end else begin
                        w_state_nxt     = S_FAIL;
                        w_cause_nxt     = 2'd1;
                        w_fail_adr_nxt  = dataadr;
                        w_fail_data_nxt = writedata;
                    end
                end else if (r_to == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_FAIL;
                    w_cause_nxt = 2'd2;
                end else begin
                    w_to_nxt = r_to + TW'(1);
                end
            end
            default: begin
                if (start) begin
                    w_cnt_nxt       = w_num_clamp;
                    w_match_nxt     = '0;
                    w_cause_nxt     = 2'd0;
                    w_fail_adr_nxt  = '0;
                    w_fail_data_nxt = '0;
                    w_to_nxt        = '0;
                    w_state_nxt     = (w_num_clamp == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_match_cnt <= '0;
            r_cause     <= '0;
            r_fail_adr  <= '0;
            r_fail_data <= '0;
            r_to        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_match_cnt <= w_match_nxt;
            r_cause     <= w_cause_nxt;
            r_fail_adr  <= w_fail_adr_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_to        <= w_to_nxt;
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_PASS) || (r_state == S_FAIL);
    assign pass       = (r_state == S_PASS);
    assign fail_cause = r_cause;
    assign fail_adr   = r_fail_adr;
    assign fail_data  = r_fail_data;
    assign match_cnt  = r_match_cnt;

endmodule

// File: tb/tb_store_monitor.sv
module tb_store_monitor;
    localparam int DW = 32, AW = 32, DEPTH = 8, TIMEOUT = 16;
    localparam int IW = 3, NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_en;
    logic [IW-1:0] ld_idx;
    logic [AW-1:0] ld_adr;
    logic [DW-1:0] ld_data;
    logic [NW-1:0] num_exp;
    logic          start;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          busy, done, pass;
    logic [1:0]    fail_cause;
    logic [AW-1:0] fail_adr;
    logic [DW-1:0] fail_data;
    logic [NW-1:0] match_cnt;

    int ncmp = 0;
    int nfail = 0;

    store_monitor #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGNORE_ADR(80)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_idx(ld_idx), .ld_adr(ld_adr),
        .ld_data(ld_data), .num_exp(num_exp), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(busy), .done(done), .pass(pass),
        .fail_cause(fail_cause), .fail_adr(fail_adr), .fail_data(fail_data),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic b, input logic d, input logic p,
                           input logic [1:0] c, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] m);
        chk({tag, ".busy"}, 64'(busy), 64'(b));
        chk({tag, ".done"}, 64'(done), 64'(d));
        chk({tag, ".pass"}, 64'(pass), 64'(p));
        chk({tag, ".cause"}, 64'(fail_cause), 64'(c));
        chk({tag, ".fadr"}, 64'(fail_adr), 64'(a));
        chk({tag, ".fdata"}, 64'(fail_data), 64'(w));
        chk({tag, ".mcnt"}, 64'(match_cnt), 64'(m));
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IW-1:0] i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_idx = i; ld_adr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic go(input logic [NW-1:0] n);
        num_exp = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_adr = '0; ld_data = '0;
        num_exp = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        tick(); tick();
        chk_res("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Branch-taken program: single store {20,0}.
        load(0, 20, 0);
        go(1);
        chk("taken.busy_run", 64'(busy), 64'd1);
        chk("taken.done_run", 64'(done), 64'd0);
        store(20, 0);
        chk_res("taken", 0, 1, 1, 0, 0, 0, 1);

        // Branch not taken: store {20,50} mismatches.
        go(1);
        store(20, 50);
        chk_res("nottaken", 0, 1, 0, 1, 20, 50, 0);

        // Scratch stores interleaved with expected ones.
        load(1, 24, 7);
        go(2);
        store(80, 11);
        store(20, 0);
        store(80, 22);
        store(24, 7);
`ifdef STORE_MONITOR_IGNORE_EN
        chk_res("ignore", 0, 1, 1, 0, 0, 0, 2);
`else
        chk_res("noignore", 0, 1, 0, 1, 80, 11, 0);
`endif

        // Timeout on the 16th idle edge after start.
        go(1);
        repeat (15) tick();
        chk("tmo.busy_15", 64'(busy), 64'd1);
        chk("tmo.done_15", 64'(done), 64'd0);
        tick();
        chk_res("tmo", 0, 1, 0, 2, 0, 0, 0);

        // A store on the would-expire cycle is evaluated instead.
        go(1);
        repeat (15) tick();
        store(20, 0);
        chk_res("tmo_store", 0, 1, 1, 0, 0, 0, 1);

        // Empty run passes immediately.
        go(0);
        chk_res("empty", 0, 1, 1, 0, 0, 0, 0);

        // Store in the start cycle is not checked.
        num_exp = 1; start = 1'b1; memwrite = 1'b1; dataadr = 5; writedata = 5;
        tick();
        start = 1'b0; memwrite = 1'b0;
        chk_res("startcyc", 1, 0, 0, 0, 0, 0, 0);
        store(20, 0);
        chk_res("startcyc_end", 0, 1, 1, 0, 0, 0, 1);

        // Asynchronous reset mid-run, then rerun with the retained table.
        go(2);
        store(20, 0);
        chk("rst.mcnt_pre", 64'(match_cnt), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk_res("rst_async", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        go(1);
        store(20, 0);
        chk_res("rst_rerun", 0, 1, 1, 0, 0, 0, 1);

        // Table writes during RUN are dropped.
        go(1);
        load(0, 99, 99);
        store(20, 0);
        chk_res("ldrun", 0, 1, 1, 0, 0, 0, 1);
        store(24, 99);
        chk_res("late_store", 0, 1, 1, 0, 0, 0, 1);

        // Restart from PASS clears results.
        go(1);
        chk_res("restart", 1, 0, 0, 0, 0, 0, 0);
        store(20, 0);
        chk_res("restart_end", 0, 1, 1, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
